// File: rtl/alu_sched_pkg.sv
// Shared opcode constants, FSM encoding and opcode classification helpers
// for the two-requester ALU scheduler (also used by the CPU control unit).
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_SLT  = 5'd11;
    localparam logic [4:0] OP_SLTU = 5'd12;
    localparam logic [4:0] OP_NOR  = 5'd13;
    localparam logic [4:0] OP_NAND = 5'd14;

    // Opcode 3 is a hole in the map; everything above NAND is unused.
    function automatic logic is_legal(input logic [4:0] sel);
        return (sel <= OP_NAND) && (sel != 5'd3);
    endfunction

    // Multiply and divide take the long execution path.
    function automatic logic is_muldiv(input logic [4:0] sel);
        return (sel == OP_MUL) || (sel == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_sched_alu.sv
// Combinational 32x32 -> 64-bit ALU. Narrow ops are zero-extended to 64 bits;
// DIV packs {remainder, quotient} and returns all ones on divide by zero.
module alu
    import alu_sched_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  sel,
    output logic [63:0] y
);

    // Opcode decode; unused opcodes produce zero.
    always_comb begin
        y = '0;
        case (sel)
            OP_ADD:  y = {32'b0, a} + {32'b0, b};
            OP_SUB:  y = {32'b0, a - b};
            OP_MUL:  y = {32'b0, a} * {32'b0, b};
            OP_DIV:  y = (b == '0) ? '1 : {a % b, a / b};
            OP_AND:  y = {32'b0, a & b};
            OP_OR:   y = {32'b0, a | b};
            OP_XOR:  y = {32'b0, a ^ b};
            OP_SLL:  y = {32'b0, a << b[4:0]};
            OP_SRL:  y = {32'b0, a >> b[4:0]};
            OP_SRA:  y = {32'b0, $unsigned($signed(a) >>> b[4:0])};
            OP_SLT:  y = {63'b0, $signed(a) < $signed(b)};
            OP_SLTU: y = {63'b0, a < b};
            OP_NOR:  y = {32'b0, ~(a | b)};
            OP_NAND: y = {32'b0, ~(a & b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Time-shares one ALU between two requesters: round-robin grant in IDLE,
// fixed-latency EXEC countdown, result held in DONE until the owner accepts.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int SIMPLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [4:0]  req_sel0,
    input  logic [4:0]  req_sel1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [3:0] CNT_MULDIV = 4'(MULDIV_CYCLES - 1);
    localparam logic [3:0] CNT_SIMPLE = 4'(SIMPLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  sel_q, sel_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [63:0] result_q, result_d;
    logic        err_q, err_d;
    logic [63:0] alu_y;
    logic        grant;
    logic [4:0]  win_sel;

    // The ALU only ever sees latched operands, so they are stable across EXEC.
    alu u_alu (
        .a   (a_q),
        .b   (b_q),
        .sel (sel_q),
        .y   (alu_y)
    );

    // Next-state, handshake and datapath-load logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        owner_d   = owner_q;
        last_d    = last_q;
        result_d  = result_q;
        err_d     = err_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        // Contested grant goes to whoever was not served last.
        grant     = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        win_sel   = grant ? req_sel1 : req_sel0;

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00 && !rst) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    a_d       = grant ? req_a1 : req_a0;
                    b_d       = grant ? req_b1 : req_b0;
                    sel_d     = win_sel;
                    owner_d   = grant;
                    if (is_legal(win_sel)) begin
                        state_d = EXEC;
                        cnt_d   = is_muldiv(win_sel) ? CNT_MULDIV : CNT_SIMPLE;
                    end else begin
                        // Illegal opcodes bypass the ALU entirely.
                        state_d  = DONE;
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    result_d = alu_y;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!rst) begin
                    rsp_valid = owner_q ? 2'b10 : 2'b01;
                end
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Randomized and directed bench for alu_sched against a behavioural model.
module tb_alu_sched;

    localparam int MDC = 4;
    localparam int SC  = 1;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [4:0]  req_sel0, req_sel1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    alu_sched #(.MULDIV_CYCLES(MDC), .SIMPLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_sel0(req_sel0), .req_sel1(req_sel1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic bit m_legal(input logic [4:0] s);
        return !(s == 5'd3 || s > 5'd14);
    endfunction

    // Cycles from acceptance to first rsp_valid.
    function automatic int m_lat(input logic [4:0] s);
        if (!m_legal(s)) return 1;
        return ((s == 5'd2 || s == 5'd4) ? MDC : SC) + 1;
    endfunction

    function automatic logic [63:0] m_res(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] A, B, M;
        logic signed [63:0] S;
        int sh;
        A = {32'b0, a}; B = {32'b0, b}; M = 64'h0000_0000_FFFF_FFFF;
        S = $signed({{32{a[31]}}, a});
        sh = int'(b % 32);
        case (s)
            5'd0:  return A + B;
            5'd1:  return (A - B) & M;
            5'd2:  return A * B;
            5'd4:  return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (((A % B) << 32) | (A / B));
            5'd5:  return A & B;
            5'd6:  return A | B;
            5'd7:  return A ^ B;
            5'd8:  return (A << sh) & M;
            5'd9:  return A >> sh;
            5'd10: return (S >>> sh) & M;
            5'd11: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            5'd12: return (a < b) ? 64'd1 : 64'd0;
            5'd13: return ~(A | B) & M;
            5'd14: return ~(A & B) & M;
            default: return 64'd0;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int r, input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin req_sel0 = s; req_a0 = a; req_b0 = b; end
        else        begin req_sel1 = s; req_a1 = a; req_b1 = b; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs one transaction with rsp_ready already high; returns observations.
    task automatic do_txn(input int r, input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res, output logic err,
                          output logic [1:0] vb, output bit to);
        int t_acc;
        bit got;
        to = 0; lat = -1; res = '0; err = 1'b0; vb = 2'b00; t_acc = 0;
        set_req(r, s, a, b);
        req_valid[r] = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin got = 1; t_acc = cyc; end
            @(posedge clk); #1;
        end
        req_valid[r] = 1'b0;
        if (!got) begin to = 1; return; end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                got = 1; lat = cyc - t_acc; res = rsp_result; err = rsp_err; vb = rsp_valid;
            end
            @(posedge clk); #1;
        end
        if (!got) to = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req_valid = 2'b11; rsp_ready = 2'b11;
        set_req(0, 5'd0, 1, 2); set_req(1, 5'd0, 3, 4);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== 64'd0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h err=%b busy=%b, want all zero",
                     req_ready, rsp_valid, rsp_result, rsp_err, busy);
        end
        @(posedge clk); #1;
        req_valid = 2'b00; rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_w, w, last;
        bit got;
        logic [31:0] a1;
        do_reset();
        a1 = 32'h1234_5678;
        set_req(0, 5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
        set_req(1, 5'd5, a1, 32'h0F0F_0F0F);
        req_valid = 2'b11;
        last = 1;
        for (int k = 0; k < 3; k++) begin
            exp_w = 1 - last;
            got = 0; w = -1;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin got = 1; w = req_ready[1] ? 1 : 0; end
                @(posedge clk); #1;
            end
            checks++;
            if (!got || w != exp_w) begin
                failures++;
                $display("FAIL rr_winner[%0d]: got %0d (rdy seen=%0d), want %0d", k, w, got, exp_w);
            end
            last = exp_w;
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (rsp_valid != 2'b00) got = 1;
                else if (req_ready !== 2'b00) begin
                    checks++; failures++;
                    $display("FAIL rr_ready_busy: req_ready=%b while busy, want 00", req_ready);
                end
                if (got) begin
                    checks++;
                    if (rsp_valid !== (exp_w ? 2'b10 : 2'b01) ||
                        rsp_result !== (exp_w ? m_res(5'd5, a1, 32'h0F0F_0F0F) : 64'h0000_0000_F000_F000)) begin
                        failures++;
                        $display("FAIL rr_result[%0d]: vld=%b res=%h, want owner %0d", k, rsp_valid, rsp_result, exp_w);
                    end
                end
                @(posedge clk); #1;
            end
            if (!got) begin
                checks++; failures++;
                $display("FAIL rr_timeout[%0d]: no response, want one", k);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_add_mul();
        int lat; logic [63:0] res; logic err; logic [1:0] vb; bit to;
        do_txn(0, 5'd0, 32'd5, 32'd7, lat, res, err, vb, to);
        checks++;
        if (to || lat != 2 || res !== 64'd12 || err !== 1'b0 || vb !== 2'b01) begin
            failures++;
            $display("FAIL add: lat=%0d res=%h err=%b vld=%b to=%0d, want lat=2 res=12 err=0 vld=01", lat, res, err, vb, to);
        end
        do_txn(1, 5'd2, 32'h0001_0000, 32'h0001_0000, lat, res, err, vb, to);
        checks++;
        if (to || lat != 5 || res !== 64'h0000_0001_0000_0000 || err !== 1'b0 || vb !== 2'b10) begin
            failures++;
            $display("FAIL mul: lat=%0d res=%h err=%b vld=%b to=%0d, want lat=5 res=100000000 vld=10", lat, res, err, vb, to);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [63:0] res; logic err; logic [1:0] vb; bit to;
        do_txn(0, 5'd3, 32'hDEAD_BEEF, 32'h1, lat, res, err, vb, to);
        checks++;
        if (to || lat != 1 || res !== 64'd0 || err !== 1'b1 || vb !== 2'b01) begin
            failures++;
            $display("FAIL illegal3: lat=%0d res=%h err=%b vld=%b, want lat=1 res=0 err=1 vld=01", lat, res, err, vb);
        end
        do_txn(1, 5'd31, 32'h5, 32'h6, lat, res, err, vb, to);
        checks++;
        if (to || lat != 1 || res !== 64'd0 || err !== 1'b1 || vb !== 2'b10) begin
            failures++;
            $display("FAIL illegal31: lat=%0d res=%h err=%b vld=%b, want lat=1 err=1 vld=10", lat, res, err, vb);
        end
        do_txn(0, 5'd1, 32'd3, 32'd10, lat, res, err, vb, to);
        checks++;
        if (to || lat != 2 || res !== 64'h0000_0000_FFFF_FFF9 || err !== 1'b0) begin
            failures++;
            $display("FAIL after_illegal: lat=%0d res=%h err=%b, want lat=2 res=fffffff9 err=0", lat, res, err);
        end
    endtask

    task automatic test_stall();
        bit got; logic [63:0] held;
        rsp_ready = 2'b10;
        set_req(0, 5'd1, 32'd100, 32'd1);
        set_req(1, 5'd7, 32'hAAAA_0000, 32'h0F0F_0F0F);
        req_valid = 2'b01;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); if (req_ready[0]) got = 1; @(posedge clk); #1;
        end
        req_valid = 2'b10;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); if (rsp_valid[0]) got = 1; else @(posedge clk);
        end
        held = rsp_result;
        checks++;
        if (!got || held !== 64'd99) begin
            failures++;
            $display("FAIL stall_result: seen=%0d res=%h, want 99", got, held);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b01 || rsp_result !== held || rsp_err !== 1'b0 || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL stall_hold[%0d]: vld=%b res=%h rdy=%b, want vld=01 res=%h rdy=00",
                         i, rsp_valid, rsp_result, req_ready, held);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL stall_next_grant: rdy=%b, want 10", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); if (rsp_valid != 2'b00) got = 1; @(posedge clk); #1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL stall_req1: no response for waiting requester 1, want one");
        end
    endtask

    task automatic test_reset_mid_exec();
        int lat; logic [63:0] res; logic err; logic [1:0] vb; bit to, got, seen;
        set_req(0, 5'd4, 32'd100, 32'd7);
        req_valid = 2'b01;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); if (req_ready[0]) got = 1; @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (!got || busy !== 1'b1) begin
            failures++;
            $display("FAIL div_exec_busy: accepted=%0d busy=%b, want 1/1", got, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== 64'd0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midexec_reset: rdy=%b vld=%b res=%h err=%b busy=%b, want all zero",
                     req_ready, rsp_valid, rsp_result, rsp_err, busy);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid != 2'b00) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abandoned_rsp: rsp_valid seen=1, want 0");
        end
        @(posedge clk); #1;
        do_txn(0, 5'd4, 32'd100, 32'd7, lat, res, err, vb, to);
        checks++;
        if (to || lat != MDC + 1 || res !== {32'd2, 32'd14} || err !== 1'b0 || vb !== 2'b01) begin
            failures++;
            $display("FAIL div_after_reset: lat=%0d res=%h err=%b vld=%b, want lat=%0d res=%h", lat, res, err, vb, MDC + 1, {32'd2, 32'd14});
        end
    endtask

    task automatic test_random();
        int lat, r; logic [63:0] res; logic err; logic [1:0] vb; bit to;
        logic [4:0] s; logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 1);
            s = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 14));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            do_txn(r, s, a, b, lat, res, err, vb, to);
            checks++;
            if (to || vb !== (r == 1 ? 2'b10 : 2'b01) || lat != m_lat(s) ||
                res !== (m_legal(s) ? m_res(s, a, b) : 64'd0) || err !== !m_legal(s)) begin
                failures++;
                $display("FAIL rand[%0d] r=%0d sel=%0d a=%h b=%h: lat=%0d res=%h err=%b vld=%b, want lat=%0d res=%h err=%b",
                         n, r, s, a, b, lat, res, err, vb, m_lat(s),
                         m_legal(s) ? m_res(s, a, b) : 64'd0, !m_legal(s));
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        set_req(0, 5'd0, 0, 0); set_req(1, 5'd0, 0, 0);
        test_reset();
        test_round_robin();
        test_add_mul();
        test_illegal();
        test_stall();
        test_reset_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

endmodule
